// File: rtl/aes_key_schedule_pkg.sv
// rtl/aes_key_schedule_pkg.sv - shared AES constants: key-length codes, Nk/Nr, Rcon, S-box
package aes_pkg;

   localparam logic [1:0] KEY_LEN_128 = 2'd0;
   localparam logic [1:0] KEY_LEN_192 = 2'd1;
   localparam logic [1:0] KEY_LEN_256 = 2'd2;
   localparam logic [1:0] KEY_LEN_BAD = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DRAIN} ks_state_e;

   function automatic logic [3:0] nk_of(input logic [1:0] key_len);
      case (key_len)
         KEY_LEN_192: nk_of = 4'd6;
         KEY_LEN_256: nk_of = 4'd8;
         default:     nk_of = 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] key_len);
      case (key_len)
         KEY_LEN_192: nr_of = 4'd12;
         KEY_LEN_256: nr_of = 4'd14;
         default:     nr_of = 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon_of = 8'h01;
         4'd2:    rcon_of = 8'h02;
         4'd3:    rcon_of = 8'h04;
         4'd4:    rcon_of = 8'h08;
         4'd5:    rcon_of = 8'h10;
         4'd6:    rcon_of = 8'h20;
         4'd7:    rcon_of = 8'h40;
         4'd8:    rcon_of = 8'h80;
         4'd9:    rcon_of = 8'h1b;
         4'd10:   rcon_of = 8'h36;
         default: rcon_of = 8'h00;
      endcase
   endfunction

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      sub_byte = SBOX[b];
   endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - start/key request and round-key stream bundle
interface aes_key_schedule_if #(parameter int KEY_W = 256);
   logic             start;
   logic [1:0]       key_len;
   logic [KEY_W-1:0] key;
   logic             rk_valid;
   logic             rk_ready;
   logic [127:0]     rk_data;
   logic [3:0]       rk_round;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, key_len, key, rk_ready,
      input  rk_valid, rk_data, rk_round, busy, done, err
   );

   modport slave (
      input  start, key_len, key, rk_ready,
      output rk_valid, rk_data, rk_round, busy, done, err
   );
endinterface

// File: rtl/aes_key_schedule_sub_word.sv
// rtl/aes_key_schedule_sub_word.sv - combinational SubWord: four parallel S-box lookups
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);

   assign sub[31:24] = sub_byte(word[31:24]);
   assign sub[23:16] = sub_byte(word[23:16]);
   assign sub[15:8]  = sub_byte(word[15:8]);
   assign sub[7:0]   = sub_byte(word[7:0]);

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128/192/256 key expansion, one word per cycle,
// round keys streamed out over a valid/ready handshake
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int KEY_W = 256
) (
   input logic                clock,
   input logic                reset,
   aes_key_schedule_if.slave  ks
);

   ks_state_e    state, state_next;
   logic [31:0]  win [8];
   logic [5:0]   word_idx;
   logic [3:0]   nk, nr, nk_mod, rc_idx;
   logic [127:0] rk_data_q;
   logic [3:0]   rk_round_q;
   logic         rk_valid_q, busy_q, done_q, err_q;

   logic         advance, accept, reject, finish, rk_load, handshake;
   logic [3:0]   req_nk;
   logic         req_legal;
   logic [255:0] key_pad;
   logic [31:0]  key_word [8];
   logic [31:0]  w_prev, w_old, sub_in, sub_out, t_word, w_new;

   assign req_nk    = nk_of(ks.key_len);
   assign req_legal = (ks.key_len != KEY_LEN_BAD) && ((32 * int'(req_nk)) <= KEY_W);
   assign key_pad   = 256'(ks.key) << (256 - KEY_W);

   always_comb begin
      for (int j = 0; j < 8; j++) begin
         key_word[j] = key_pad[255 - 32*j -: 32];
      end
   end

   // The window is right-aligned: win[7] = w[i-1], win[8-Nk] = w[i-Nk].
   // The key is preloaded rotated so the same read slot yields key words for i < Nk.
   assign w_prev = win[7];
   assign w_old  = win[3'(8 - int'(nk))];
   assign sub_in = (nk_mod == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   aes_sub_word u_sub_word (
      .word (sub_in),
      .sub  (sub_out)
   );

   always_comb begin
      t_word = w_prev;
      if (nk_mod == 4'd0) begin
         t_word = sub_out ^ {rcon_of(rc_idx), 24'h0};
      end else if (nk == 4'd8 && nk_mod == 4'd4) begin
         t_word = sub_out;
      end
      w_new = (rc_idx == 4'd0) ? w_old : (w_old ^ t_word);
   end

   assign handshake = rk_valid_q && ks.rk_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      advance    = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ks.start) begin
               if (req_legal) begin
                  accept     = 1'b1;
                  state_next = ST_GEN;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_GEN: begin
            // Stall only when a round-key load would overwrite an unaccepted key.
            advance = !(word_idx[1:0] == 2'd3 && rk_valid_q && !ks.rk_ready);
            if (advance && word_idx == {nr, 2'b11}) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (handshake) begin
               finish     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign rk_load = advance && (word_idx[1:0] == 2'd3);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int p = 0; p < 8; p++) begin
            win[p] <= '0;
         end
         word_idx   <= '0;
         nk         <= 4'd4;
         nr         <= 4'd10;
         nk_mod     <= '0;
         rc_idx     <= '0;
         rk_data_q  <= '0;
         rk_round_q <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= finish;
         err_q  <= reject;
         if (accept) begin
            busy_q   <= 1'b1;
            word_idx <= '0;
            nk       <= req_nk;
            nr       <= nr_of(ks.key_len);
            nk_mod   <= '0;
            rc_idx   <= '0;
            for (int p = 0; p < 8; p++) begin
               win[p] <= key_word[3'(p + int'(req_nk))];
            end
         end
         if (finish) begin
            busy_q <= 1'b0;
         end
         if (advance) begin
            word_idx <= word_idx + 6'd1;
            for (int p = 0; p < 7; p++) begin
               win[p] <= win[p+1];
            end
            win[7] <= w_new;
            if (nk_mod == nk - 4'd1) begin
               nk_mod <= '0;
               rc_idx <= rc_idx + 4'd1;
            end else begin
               nk_mod <= nk_mod + 4'd1;
            end
         end
         if (rk_load) begin
            rk_data_q  <= {win[5], win[6], win[7], w_new};
            rk_round_q <= word_idx[5:2];
            rk_valid_q <= 1'b1;
         end else if (handshake) begin
            rk_valid_q <= 1'b0;
         end
      end
   end

   assign ks.rk_valid = rk_valid_q;
   assign ks.rk_data  = rk_data_q;
   assign ks.rk_round = rk_round_q;
   assign ks.busy     = busy_q;
   assign ks.done     = done_q;
   assign ks.err      = err_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - randomized self-checking bench for aes_key_schedule
module tb_aes_key_schedule;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   aes_key_schedule_if #(.KEY_W(256)) ks ();
   aes_key_schedule_if #(.KEY_W(128)) ks_n ();

   aes_key_schedule #(.KEY_W(256)) dut   (.clock(clock), .reset(reset), .ks(ks));
   aes_key_schedule #(.KEY_W(128)) dut_n (.clock(clock), .reset(reset), .ks(ks_n));

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox_ref [256];
   logic [127:0] exp_rk [15];
   logic [127:0] got_rk [15];

   localparam logic [255:0] KAT128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KAT192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KAT256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ a;
         a = xtime(a);
      end
      gmul = p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] base = x;
      logic [7:0] s;
      int e = 254;
      while (e != 0) begin
         if (e % 2 == 1) r = gmul(r, base);
         base = gmul(base, base);
         e = e / 2;
      end
      s = r;
      for (int n = 1; n <= 4; n++) s = s ^ ((r << n) | (r >> (8 - n)));
      sbox_calc = s ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
      sub_word_ref = {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_ref(input int n);
      logic [7:0] r = 8'h01;
      for (int k = 1; k < n; k++) r = xtime(r);
      rcon_ref = r;
   endfunction

   task automatic expand(input int nk, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      int nr = nk + 6;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = key[255 - 32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) t = sub_word_ref({t[23:0], t[31:24]}) ^ {rcon_ref(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word_ref(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic run_key(input logic [1:0] len, input logic [255:0] key, input int low_pct,
                          input bit poke, input string name);
      int nk = 4 + 2 * int'(len);
      int nr = nk + 6;
      int n = 0, done_cnt = 0, cyc = 0, last_vis = -1, done_cyc = -1;
      bit stall = 1'b0, err_seen = 1'b0, rdy;
      logic [127:0] prev_d = '0;
      logic [3:0]   prev_r = '0;
      expand(nk, key);
      @(negedge clock);
      ks.start = 1'b1; ks.key_len = len; ks.key = key; ks.rk_ready = 1'b1;
      @(negedge clock);
      ks.start = 1'b0;
      check({name, "_busy"}, 160'(ks.busy), 160'(1));
      while (done_cnt == 0 && cyc < 600) begin
         if (stall) check({name, "_stable"}, 160'({ks.rk_valid, ks.rk_round, ks.rk_data}),
                          160'({1'b1, prev_r, prev_d}));
         if (ks.err) err_seen = 1'b1;
         if (ks.done) begin
            done_cnt++; done_cyc = cyc;
            check({name, "_busy_at_done"}, 160'(ks.busy), 160'(0));
         end
         if (ks.rk_valid && int'(ks.rk_round) == nr && last_vis < 0) last_vis = cyc;
         rdy = ($urandom_range(99) >= low_pct);
         ks.rk_ready = rdy;
         if (poke) begin
            ks.start = (cyc == 10);
            ks.key_len = 2'd3;
         end
         if (ks.rk_valid && rdy) begin
            if (n <= nr) begin
               got_rk[n] = ks.rk_data;
               check({name, "_round"}, 160'(ks.rk_round), 160'(n));
               check({name, "_rk"}, 160'(ks.rk_data), 160'(exp_rk[n]));
            end else begin
               check({name, "_extra_rk"}, 160'(n), 160'(nr));
            end
            n++;
         end
         stall = ks.rk_valid && !rdy;
         prev_d = ks.rk_data;
         prev_r = ks.rk_round;
         @(negedge clock);
         cyc++;
      end
      ks.start = 1'b0;
      ks.rk_ready = 1'b1;
      check({name, "_done_once"}, 160'(done_cnt), 160'(1));
      check({name, "_key_count"}, 160'(n), 160'(nr + 1));
      check({name, "_no_err"}, 160'(err_seen), 160'(0));
      if (low_pct == 0) begin
         check({name, "_last_valid_cyc"}, 160'(last_vis), 160'(4 * nr + 4));
         check({name, "_done_cyc"}, 160'(done_cyc), 160'(4 * nr + 5));
      end
      repeat (3) begin
         check({name, "_quiet"}, 160'({ks.done, ks.rk_valid, ks.busy}), 160'(0));
         @(negedge clock);
      end
   endtask

   initial begin
      int cyc;
      int seen;
      for (int b = 0; b < 256; b++) sbox_ref[b] = sbox_calc(8'(b));

      reset = 1'b1;
      ks.start = 1'b0; ks.key_len = 2'd0; ks.key = '0; ks.rk_ready = 1'b1;
      ks_n.start = 1'b0; ks_n.key_len = 2'd0; ks_n.key = '0; ks_n.rk_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_state", 160'({ks.rk_valid, ks.busy, ks.done, ks.err, ks.rk_round, ks.rk_data}), 160'(0));
      reset = 1'b0;

      run_key(2'd0, KAT128, 0, 1'b0, "kat128");
      check("kat128_r1", 160'(got_rk[1]), 160'(128'ha0fafe1788542cb123a339392a6c7605));
      check("kat128_r10", 160'(got_rk[10]), 160'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
      run_key(2'd1, KAT192, 0, 1'b0, "kat192");
      check("kat192_r12", 160'(got_rk[12]), 160'(128'he98ba06f448c773c8ecc720401002202));
      run_key(2'd2, KAT256, 0, 1'b0, "kat256");
      check("kat256_r14", 160'(got_rk[14]), 160'(128'hfe4890d1e6188d0b046df344706c631e));

      for (int m = 0; m < 3; m++) begin
         for (int k = 0; k < 2; k++) begin
            run_key(2'(m), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    40, (k == 0), "bp");
         end
      end

      @(negedge clock);
      ks.start = 1'b1; ks.key_len = 2'd3;
      ks_n.start = 1'b1; ks_n.key_len = 2'd2;
      @(negedge clock);
      ks.start = 1'b0; ks_n.start = 1'b0;
      check("err_len3", 160'({ks.err, ks.busy}), 160'(2'b10));
      check("err_narrow", 160'({ks_n.err, ks_n.busy}), 160'(2'b10));
      @(negedge clock);
      check("err_len3_pulse", 160'({ks.err, ks.busy, ks.rk_valid}), 160'(0));
      check("err_narrow_pulse", 160'({ks_n.err, ks_n.busy, ks_n.rk_valid}), 160'(0));
      repeat (6) begin
         @(negedge clock);
         check("err_idle", 160'({ks.rk_valid, ks.busy, ks_n.rk_valid, ks_n.busy}), 160'(0));
      end
      ks_n.start = 1'b1; ks_n.key_len = 2'd0; ks_n.key = KAT128[255:128];
      @(negedge clock);
      ks_n.start = 1'b0;
      check("narrow_accepts_128", 160'({ks_n.err, ks_n.busy}), 160'(2'b01));

      expand(8, KAT256);
      ks.start = 1'b1; ks.key_len = 2'd2; ks.key = KAT256; ks.rk_ready = 1'b1;
      @(negedge clock);
      ks.start = 1'b0;
      cyc = 0;
      while (!(ks.rk_valid && ks.rk_round == 4'd5) && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      check("rst_reach_r5", 160'(cyc < 100), 160'(1));
      check("rst_r5_data", 160'(ks.rk_data), 160'(exp_rk[5]));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_outputs", 160'({ks.rk_valid, ks.busy, ks.done, ks.err, ks.rk_round, ks.rk_data}), 160'(0));
      seen = 0;
      repeat (30) begin
         @(negedge clock);
         if (ks.done || ks.rk_valid || ks.busy) seen++;
      end
      check("rst_no_done", 160'(seen), 160'(0));

      run_key(2'd0, KAT128, 0, 1'b0, "post_rst");
      check("post_rst_r1", 160'(got_rk[1]), 160'(128'ha0fafe1788542cb123a339392a6c7605));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
